// File: rtl/issue_scheduler.sv
// Dual-issue sequencer: splits an intra-pair dependent decode pair across two cycles.
// Optional performance counters are built only when ISSUE_PERF_CNT_EN is defined.
module issue_scheduler #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_d1,
  input  logic                  valid_d2,
  input  logic [REG_ADDR_W-1:0] rd_d1,
  input  logic [REG_ADDR_W-1:0] rd_d2,
  input  logic                  regwrite_d1,
  input  logic                  regwrite_d2,
  input  logic [REG_ADDR_W-1:0] rs1_d2,
  input  logic [REG_ADDR_W-1:0] rs2_d2,
  input  logic                  uses_rs1_d2,
  input  logic                  uses_rs2_d2,
  input  logic                  stall_ext,
  input  logic                  flush,
  output logic                  issue1,
  output logic                  issue2,
  output logic                  hold_fetch,
  output logic                  split_active,
  output logic [CNT_W-1:0]      pair_cnt,
  output logic [CNT_W-1:0]      split_cnt
);

  typedef enum logic {
    PAIR  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_raw1;
  logic   w_raw2;
  logic   w_waw;
  logic   w_dep;
  logic   w_enter_split;

  assign w_raw1 = uses_rs1_d2 & (rs1_d2 == rd_d1);
  assign w_raw2 = uses_rs2_d2 & (rs2_d2 == rd_d1);
  assign w_waw  = regwrite_d2 & (rd_d2 == rd_d1);
  assign w_dep  = valid_d1 & valid_d2 & regwrite_d1 & (rd_d1 != '0)
                & (w_raw1 | w_raw2 | w_waw);

  always_comb begin
    issue1        = 1'b0;
    issue2        = 1'b0;
    hold_fetch    = 1'b0;
    w_state_nxt   = r_state;
    w_enter_split = 1'b0;
    case (r_state)
      PAIR: begin
        if (flush) begin
          w_state_nxt = PAIR;
        end else if (stall_ext) begin
          hold_fetch = 1'b1;
        end else if (w_dep) begin
          issue1        = 1'b1;
          hold_fetch    = 1'b1;
          w_state_nxt   = SPLIT;
          w_enter_split = 1'b1;
        end else begin
          issue1 = valid_d1;
          issue2 = valid_d2;
        end
      end
      SPLIT: begin
        // Slot 1 already left; decode is frozen so slot 2 is still presented.
        if (flush) begin
          w_state_nxt = PAIR;
        end else if (stall_ext) begin
          hold_fetch = 1'b1;
        end else begin
          issue2      = valid_d2;
          w_state_nxt = PAIR;
        end
      end
      default: w_state_nxt = PAIR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PAIR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign split_active = (r_state == SPLIT);

`ifdef ISSUE_PERF_CNT_EN
  logic [CNT_W-1:0] r_pair_cnt;
  logic [CNT_W-1:0] r_split_cnt;

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pair_cnt  <= '0;
      r_split_cnt <= '0;
    end else begin
      if (issue1 && issue2 && (r_pair_cnt != '1)) begin
        r_pair_cnt <= r_pair_cnt + CNT_W'(1);
      end
      if (w_enter_split && (r_split_cnt != '1)) begin
        r_split_cnt <= r_split_cnt + CNT_W'(1);
      end
    end
  end

  assign pair_cnt  = r_pair_cnt;
  assign split_cnt = r_split_cnt;
`else
  assign pair_cnt  = '0;
  assign split_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: pending-slot-2 reference model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_issue_scheduler;

  localparam int RW = 5;
  localparam int CW = 32;
`ifdef ISSUE_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_d1, valid_d2;
  logic [RW-1:0] rd_d1, rd_d2, rs1_d2, rs2_d2;
  logic          regwrite_d1, regwrite_d2, uses_rs1_d2, uses_rs2_d2;
  logic          stall_ext, flush;
  logic          issue1, issue2, hold_fetch, split_active;
  logic [CW-1:0] pair_cnt, split_cnt;

  int total = 0;
  int bad   = 0;

  issue_scheduler #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_d1(valid_d1), .valid_d2(valid_d2),
    .rd_d1(rd_d1), .rd_d2(rd_d2),
    .regwrite_d1(regwrite_d1), .regwrite_d2(regwrite_d2),
    .rs1_d2(rs1_d2), .rs2_d2(rs2_d2),
    .uses_rs1_d2(uses_rs1_d2), .uses_rs2_d2(uses_rs2_d2),
    .stall_ext(stall_ext), .flush(flush),
    .issue1(issue1), .issue2(issue2), .hold_fetch(hold_fetch),
    .split_active(split_active), .pair_cnt(pair_cnt), .split_cnt(split_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] cexp(input int n);
    return CNT_ON ? 64'(n) : 64'd0;
  endfunction

  // Reference model: "is slot 2 of an already-half-issued pair still waiting?"
  bit      m_pend;
  longint  m_pairs, m_splits;

  function automatic bit model_dep();
    if (!(valid_d1 && valid_d2 && regwrite_d1) || rd_d1 == 0) return 1'b0;
    return (uses_rs1_d2 && rs1_d2 == rd_d1) || (uses_rs2_d2 && rs2_d2 == rd_d1)
        || (regwrite_d2 && rd_d2 == rd_d1);
  endfunction

  always @(negedge clk) begin
    bit e1, e2, eh;
    if (!rst_n) begin
      m_pend = 1'b0; m_pairs = 0; m_splits = 0;
    end
    e1 = 1'b0; e2 = 1'b0; eh = 1'b0;
    if (flush) begin
    end else if (stall_ext) eh = 1'b1;
    else if (m_pend) e2 = valid_d2;
    else if (model_dep()) begin e1 = 1'b1; eh = 1'b1; end
    else begin e1 = valid_d1; e2 = valid_d2; end
    chk("m_issue1", 64'(issue1), 64'(e1));
    chk("m_issue2", 64'(issue2), 64'(e2));
    chk("m_hold", 64'(hold_fetch), 64'(eh));
    chk("m_split_active", 64'(split_active), 64'(m_pend));
    chk("m_pair_cnt", 64'(pair_cnt), cexp(int'(m_pairs)));
    chk("m_split_cnt", 64'(split_cnt), cexp(int'(m_splits)));
    if (rst_n) begin
      if (flush) m_pend = 1'b0;
      else if (!stall_ext) begin
        if (m_pend) m_pend = 1'b0;
        else if (model_dep()) begin m_pend = 1'b1; m_splits++; end
      end
      if (e1 && e2 && m_pairs < 64'hFFFF_FFFF) m_pairs++;
    end
  end

  task automatic set_in(input bit v1, v2, input int r1, r2, input bit w1, w2,
                        input int s1, s2, input bit u1, u2);
    valid_d1 = v1; valid_d2 = v2; rd_d1 = RW'(r1); rd_d2 = RW'(r2);
    regwrite_d1 = w1; regwrite_d2 = w2; rs1_d2 = RW'(s1); rs2_d2 = RW'(s2);
    uses_rs1_d2 = u1; uses_rs2_d2 = u2;
  endtask

  task automatic tick();  @(posedge clk); #1; endtask
  task automatic probe(); @(negedge clk); #1; endtask

  task automatic chk_iss(input string tag, input bit e1, e2, eh);
    chk({tag, "_issue1"}, 64'(issue1), 64'(e1));
    chk({tag, "_issue2"}, 64'(issue2), 64'(e2));
    chk({tag, "_hold"}, 64'(hold_fetch), 64'(eh));
  endtask

  task automatic indep(); set_in(1, 1, 5, 8, 1, 1, 6, 7, 1, 1); endtask
  task automatic raw();   set_in(1, 1, 5, 8, 1, 1, 6, 5, 0, 1); endtask

  initial begin
    rst_n = 1'b0; stall_ext = 1'b0; flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("rst_split_active", 64'(split_active), 64'd0);
    chk("rst_pair_cnt", 64'(pair_cnt), 64'd0);
    chk("rst_split_cnt", 64'(split_cnt), 64'd0);
    rst_n = 1'b1;

    // Independent pair, four cycles
    indep();
    for (int i = 0; i < 4; i++) begin
      probe(); chk_iss("indep", 1, 1, 0); tick();
    end
    chk("indep_pair_cnt", 64'(pair_cnt), cexp(4));

    // RAW split on rs2
    raw();
    probe(); chk_iss("raw_n", 1, 0, 1);
    chk("raw_n_sa", 64'(split_active), 64'd0);
    tick();
    chk("raw_sa", 64'(split_active), 64'd1);
    chk("raw_split_cnt", 64'(split_cnt), cexp(1));
    probe(); chk_iss("raw_n1", 0, 1, 0);
    tick();
    chk("raw_sa_back", 64'(split_active), 64'd0);
    chk("raw_pair_cnt", 64'(pair_cnt), cexp(4));

    // x0 destination and disabled regwrite do not split
    set_in(1, 1, 0, 8, 1, 1, 0, 7, 1, 0);
    probe(); chk_iss("x0", 1, 1, 0); tick();
    set_in(1, 1, 5, 8, 0, 1, 5, 7, 1, 1);
    probe(); chk_iss("nowr", 1, 1, 0); tick();
    chk("x0_pair_cnt", 64'(pair_cnt), cexp(6));
    chk("x0_split_cnt", 64'(split_cnt), cexp(1));

    // Three-cycle stall while in SPLIT
    raw();
    probe(); chk_iss("stl_n", 1, 0, 1); tick();
    stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      probe(); chk_iss("stl_hold", 0, 0, 1);
      chk("stl_sa", 64'(split_active), 64'd1);
      tick();
    end
    stall_ext = 1'b0;
    probe(); chk_iss("stl_release", 0, 1, 0); tick();
    chk("stl_sa_back", 64'(split_active), 64'd0);
    chk("stl_split_cnt", 64'(split_cnt), cexp(2));

    // WAW split, then flush in SPLIT drops slot 2
    set_in(1, 1, 9, 9, 1, 1, 1, 2, 0, 0);
    probe(); chk_iss("waw_n", 1, 0, 1); tick();
    flush = 1'b1;
    probe(); chk_iss("waw_flush", 0, 0, 0); tick();
    chk("waw_sa", 64'(split_active), 64'd0);
    flush = 1'b0;
    indep();
    probe(); chk_iss("waw_after", 1, 1, 0); tick();
    chk("waw_pair_cnt", 64'(pair_cnt), cexp(7));
    chk("waw_split_cnt", 64'(split_cnt), cexp(3));

    // Flush coincident with dep: nothing issues, no SPLIT
    raw(); flush = 1'b1;
    probe(); chk_iss("fdep", 0, 0, 0); tick();
    chk("fdep_sa", 64'(split_active), 64'd0);
    chk("fdep_split_cnt", 64'(split_cnt), cexp(3));
    flush = 1'b0;

    // Stall beats dep in PAIR
    stall_ext = 1'b1;
    probe(); chk_iss("sdep", 0, 0, 1); tick();
    chk("sdep_sa", 64'(split_active), 64'd0);
    stall_ext = 1'b0;

    // Reset asserted mid-split
    probe(); chk_iss("rs_n", 1, 0, 1); tick();
    chk("rs_sa", 64'(split_active), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_sa", 64'(split_active), 64'd0);
    chk("rs_async_pair", 64'(pair_cnt), 64'd0);
    chk("rs_async_split", 64'(split_cnt), 64'd0);
    chk("rs_async_issue2", 64'(issue2), 64'd0);
    @(negedge clk); tick();
    indep();
    #2 rst_n = 1'b1;
    probe(); chk_iss("rs_resume", 1, 1, 0);
    chk("rs_resume_sa", 64'(split_active), 64'd0);
    tick();
    chk("rs_pair_cnt", 64'(pair_cnt), cexp(1));

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Dual-issue sequencing controller for the superscalar decode stage. Detects intra-pair register dependencies between decode slot 1 and slot 2 and splits a dependent pair across two cycles. Slot 1 issues first; slot 2 issues on the following cycle. It drives the per-slot issue enables and the fetch/decode hold, and coordinates the split with external stalls and branch flushes.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_d1 / valid_d2  in  1  decode slot holds a valid instruction
- rd_d1 / rd_d2  in  REG_ADDR_W  destination register per slot
- regwrite_d1 / regwrite_d2  in  1  slot writes rd
- rs1_d2 / rs2_d2  in  REG_ADDR_W  slot 2 source registers
- uses_rs1_d2 / uses_rs2_d2  in  1  slot 2 reads the corresponding source
- stall_ext  in  1  global stall from the hazard or memory path
- flush  in  1  branch or jump redirect; kills both decode slots
- issue1 / issue2  out  1  slot advances into execute this cycle; 0 inserts a bubble
- hold_fetch  out  1  freeze the PC and the fetch/decode pipeline registers
- split_active  out  1  registered; 1 while in SPLIT state
- pair_cnt  out  CNT_W  cycles with issue1 and issue2 both high
- split_cnt  out  CNT_W  dependent pairs split

## Operation
Dependency (combinational):
- dep = valid_d1 & valid_d2 & regwrite_d1 & (rd_d1 != 0) & (RAW1 | RAW2 | WAW)
- RAW1 = uses_rs1_d2 & (rs1_d2 == rd_d1)
- RAW2 = uses_rs2_d2 & (rs2_d2 == rd_d1)
- WAW = regwrite_d2 & (rd_d2 == rd_d1)
- x0 never creates a dependency.

FSM: 1-bit state, PAIR (reset) and SPLIT. Outputs are Mealy. Priority is flush > stall_ext > dep.

PAIR state:
- flush: issue1=0, issue2=0, hold_fetch=0; stay in PAIR.
- stall_ext: issue1=0, issue2=0, hold_fetch=1; stay in PAIR.
- dep: issue1=1, issue2=0, hold_fetch=1; go to SPLIT.
- otherwise: issue1=valid_d1, issue2=valid_d2, hold_fetch=0.

SPLIT state (decode registers are held, so slot 2 is still present):
- flush: issue1=0, issue2=0, hold_fetch=0; go to PAIR.
- stall_ext: issue1=0, issue2=0, hold_fetch=1; stay in SPLIT.
- otherwise: issue1=0 (slot 1 already issued), issue2=valid_d2, hold_fetch=0; go to PAIR. dep is ignored in this state.

## Timing
- Reset (rst_n=0, asynchronous): state=PAIR, split_active=0, pair_cnt=0, split_cnt=0. issue1, issue2 and hold_fetch then follow the PAIR rules.
- Each split costs exactly one extra cycle. Slot 2 issues on the first non-stalled, non-flushed cycle after slot 1.
- Deasserting stall_ext resumes from the held state with no lost or duplicated issue.
- A flush coincident with dep issues nothing and does not enter SPLIT.
- A flush while in SPLIT drops slot 2 and returns to PAIR in 1 cycle.
- Reset asserted mid-split aborts to PAIR immediately; slot 2 is not issued.
- Counter updates are registered: the count is visible the cycle after the event.

## Configuration
ISSUE_PERF_CNT_EN:
- Defined: pair_cnt and split_cnt count as specified and saturate at all-ones. split_cnt increments on each PAIR->SPLIT transition.
- Undefined: no counter flops are built; pair_cnt and split_cnt are tied to 0. Ports are kept in both cases for a stable interface.

## Test plan
- Independent pair (rd_d1=5, rs1_d2=6, rs2_d2=7, rd_d2=8): issue1=issue2=1 and hold_fetch=0 every cycle; pair_cnt increments by 1 per cycle.
- RAW split (rd_d1=5, rs2_d2=5, uses_rs2_d2=1): cycle N issue1=1, issue2=0, hold_fetch=1; cycle N+1 issue1=0, issue2=1, hold_fetch=0; split_cnt=1.
- x0 and disabled operands: rd_d1=0 with rs1_d2=0, and regwrite_d1=0 with rs1_d2==rd_d1 → no split, issue1=issue2=1.
- stall_ext held 3 cycles while in SPLIT: issue1=issue2=0 and hold_fetch=1 for all 3 cycles; issue2=1 on the cycle stall_ext drops.
- flush in SPLIT, WAW case (rd_d1=rd_d2=9): issue2 never asserts; the next cycle is in PAIR with split_active=0.
- rst_n pulsed low mid-SPLIT: split_active=0 and both counters=0 asynchronously; normal pairing resumes after rst_n rises.
